// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide beside the EX-stage ALU, stalling the pipe while it runs.
// Define FAST_MUL_EN to compute MUL* with a single-cycle combinational product instead.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [2:0] f3;
  logic sa, sb;
  logic [XLEN-1:0] m, lo;
  logic [XLEN:0] acc;
  logic [CNT_W-1:0] cnt;
  logic sgn_a, sgn_b, neg_a, neg_b, div_zero, ovf, fast, div_ge;
  logic [XLEN-1:0] mag_a, mag_b, special_res, fast_res, quo, rem, mul_res, fix_res;
  logic [XLEN:0] mul_sum, div_sh;
  logic [2*XLEN-1:0] prod, prod_s;
  assign sgn_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign sgn_b = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign neg_a = sgn_a & op_a[XLEN-1];
  assign neg_b = sgn_b & op_b[XLEN-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;
  assign div_zero = funct3[2] & (op_b == '0);
  assign ovf = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
  assign special_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p, fast_ps;
  assign fast_p = mag_a * mag_b;
  assign fast_ps = (neg_a ^ neg_b) ? -fast_p : fast_p;
  assign fast = ~funct3[2];
  assign fast_res = (funct3 == 3'b000) ? fast_ps[XLEN-1:0] : fast_ps[2*XLEN-1:XLEN];
`else
  assign fast = 1'b0;
  assign fast_res = '0;
`endif
  // Multiply: {acc, lo} shifts right, adding the multiplicand into the top half.
  assign mul_sum = {1'b0, acc[XLEN-1:0]} + (lo[0] ? {1'b0, m} : '0);
  // Divide: dividend shifts out of lo into the partial remainder, quotient bits shift in.
  assign div_sh = {acc[XLEN-1:0], lo[XLEN-1]};
  assign div_ge = div_sh >= {1'b0, m};
  assign prod = {acc[XLEN-1:0], lo};
  assign prod_s = (sa ^ sb) ? -prod : prod;
  assign mul_res = (f3 == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign quo = (sa ^ sb) ? -lo : lo;
  assign rem = sa ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign fix_res = f3[2] ? (f3[1] ? rem : quo) : mul_res;
  assign busy = state != IDLE;
  assign done = (state == DONE) & ~flush;
  assign stall = rst_n & ~flush & (((state == IDLE) & start) | (state == CALC) | (state == FIX));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      f3 <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      m <= '0;
      lo <= '0;
      acc <= '0;
      cnt <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          f3 <= funct3;
          sa <= neg_a;
          sb <= neg_b;
          acc <= '0;
          cnt <= CNT_W'(XLEN);
          lo <= funct3[2] ? mag_a : mag_b;
          m <= funct3[2] ? mag_b : mag_a;
          if (div_zero | ovf) result <= special_res;
          else if (fast) result <= fast_res;
          state <= (div_zero | ovf | fast) ? DONE : CALC;
        end
        CALC: begin
          acc <= f3[2] ? (div_ge ? div_sh - {1'b0, m} : div_sh) : {1'b0, mul_sum[XLEN:1]};
          lo <= f3[2] ? {lo[XLEN-2:0], div_ge} : {mul_sum[0], lo[XLEN-1:1]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed RV32M vectors; expected results queue up at issue and a monitor checks each done pulse.
module tb_muldiv_sequencer;
  typedef struct {logic [31:0] res; int cyc; string name;} exp_t;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  logic clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic stall, busy, done;
  logic [31:0] result;
  int cyc = 0, checks = 0, failures = 0;
  exp_t q[$];
  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && done) begin
    if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
    else begin
      exp_t e;
      e = q.pop_front();
      check({e.name, "_result"}, result, e.res);
      check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
    end
  end
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    @(posedge clk);
    #1;
    start = 1; funct3 = f; op_a = a; op_b = b;
    q.push_back('{exp, cyc + lat, name});
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      check({name, "_stall"}, 32'(stall), 32'(i < lat));
      check({name, "_busy"}, 32'(busy), 32'(i > 0));
      @(posedge clk);
      #1;
      start = 0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    end
  endtask
  initial begin
    #1;
    check("reset_stall", 32'(stall), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", result, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_op("mul_7_m3", 3'b000, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MUL_LAT);
    run_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mul_2p32", 3'b000, 32'h1_0000, 32'h1_0000, 32'h0, MUL_LAT);
    run_op("mulhu_2p32", 3'b011, 32'h1_0000, 32'h1_0000, 32'h1, MUL_LAT);
    run_op("div_m20_6", 3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34);
    run_op("rem_m20_6", 3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 34);
    run_op("divu_20_6", 3'b101, 32'd20, 32'd6, 32'd3, 34);
    run_op("remu_20_6", 3'b111, 32'd20, 32'd6, 32'd2, 34);
    run_op("div_20_m6", 3'b100, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 34);
    run_op("rem_20_m6", 3'b110, 32'd20, 32'hFFFF_FFFA, 32'd2, 34);
    run_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_7_0", 3'b111, 32'd7, 32'd0, 32'd7, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
    run_op("remu_big", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    // Flush a DIVU in flight at cycle 10: no done pulse may follow.
    @(posedge clk);
    #1 start = 1; funct3 = 3'b101; op_a = 32'd20; op_b = 32'd6;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    #1;
    check("flush_stall", 32'(stall), 0);
    check("flush_busy_before_edge", 32'(busy), 1);
    check("flush_done", 32'(done), 0);
    @(posedge clk);
    #1 flush = 0;
    #1;
    check("flush_idle_busy", 32'(busy), 0);
    check("flush_result_kept", result, 32'h8000_0000);
    repeat (40) @(posedge clk);
    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);
    // Reset at cycle 15 of a DIV: outputs clear immediately.
    @(posedge clk);
    #1 start = 1; funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk);
    #1 start = 0;
    repeat (14) @(posedge clk);
    #1;
    check("pre_reset_stall", 32'(stall), 1);
    rst_n = 0;
    #1;
    check("midreset_stall", 32'(stall), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_done", 32'(done), 0);
    check("midreset_result", result, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (40) @(posedge clk);
    run_op("post_reset_divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op("post_reset_mul", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
